// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through
// IDLE/FETCH/DECODE/EXEC/MEM/WB and drives datapath and memory controls.
// Moore outputs are registered from the next state so they line up with
// the state register. The FETCH load strobes and branch_taken are Mealy.
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iorD,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch_taken,
    output logic             reg_Write,
    output logic [1:0]       reg_Dest,
    output logic [1:0]       memtoReg,
    output logic [1:0]       aluop,
    output logic             alu_Source,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd4;
    localparam logic [5:0] OP_SW   = 6'd5;
    localparam logic [5:0] OP_BEQ  = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd7;

    state_t     state_q, nxt;
    logic [5:0] op_q, op_nxt;
    logic       retire, op_legal;
    logic       mem_req_d, mem_we_d, iorD_d, reg_Write_d, alu_Source_d;
    logic [1:0] reg_Dest_d, memtoReg_d, aluop_d;

    assign op_legal = (op_q == OP_R) || (op_q == OP_LW) || (op_q == OP_SW) ||
                      (op_q == OP_BEQ) || (op_q == OP_ADDI);

    // Next state plus the Moore output values that go with it
    always_comb begin
        nxt          = state_q;
        retire       = 1'b0;
        op_nxt       = (state_q == S_DECODE) ? opcode : op_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        iorD_d       = 1'b0;
        reg_Write_d  = 1'b0;
        reg_Dest_d   = 2'b00;
        memtoReg_d   = 2'b00;
        aluop_d      = 2'b00;
        alu_Source_d = 1'b0;

        case (state_q)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH:  if (mem_ack) nxt = S_DECODE;
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (op_q == OP_R || op_q == OP_ADDI)      nxt = S_WB;
                else if (op_q == OP_LW || op_q == OP_SW) nxt = S_MEM;
                else                                     retire = 1'b1;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_SW) retire = 1'b1;
                    else               nxt = S_WB;
                end
            end
            S_WB:     retire = 1'b1;
            default:  nxt = S_IDLE;
        endcase

        // run only matters at the instruction boundary
        if (retire) nxt = run ? S_FETCH : S_IDLE;

        case (nxt)
            S_FETCH: begin
                mem_req_d = 1'b1;
                aluop_d   = 2'b11;
            end
            S_EXEC: begin
                if (op_nxt == OP_LW || op_nxt == OP_SW || op_nxt == OP_ADDI) begin
                    aluop_d      = 2'b11;
                    alu_Source_d = 1'b1;
                end else if (op_nxt == OP_BEQ) begin
                    aluop_d = 2'b01;
                end
            end
            S_MEM: begin
                mem_req_d    = 1'b1;
                mem_we_d     = (op_nxt == OP_SW);
                iorD_d       = 1'b1;
                aluop_d      = 2'b11;
                alu_Source_d = 1'b1;
            end
            S_WB: begin
                reg_Write_d = 1'b1;
                reg_Dest_d  = (op_nxt == OP_R)  ? 2'b01 : 2'b00;
                memtoReg_d  = (op_nxt == OP_LW) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    // State, latched opcode, status and registered Moore outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= 6'd0;
            illegal    <= 1'b0;
            retired    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            iorD       <= 1'b0;
            reg_Write  <= 1'b0;
            reg_Dest   <= 2'b00;
            memtoReg   <= 2'b00;
            aluop      <= 2'b00;
            alu_Source <= 1'b0;
        end else begin
            state_q    <= nxt;
            op_q       <= op_nxt;
            if (state_q == S_EXEC && !op_legal) illegal <= 1'b1;
            if (retire && op_legal)             retired <= retired + CNT_W'(1);
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            iorD       <= iorD_d;
            reg_Write  <= reg_Write_d;
            reg_Dest   <= reg_Dest_d;
            memtoReg   <= memtoReg_d;
            aluop      <= aluop_d;
            alu_Source <= alu_Source_d;
        end
    end

    // Mealy strobes respond to the handshake / flag in the same cycle
    assign ir_write     = (state_q == S_FETCH) && mem_ack;
    assign pc_write     = (state_q == S_FETCH) && mem_ack;
    assign branch_taken = (state_q == S_EXEC) && (op_q == OP_BEQ) && zero;
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer. A narrow counter width keeps the
// wrap-around scenario short; each instruction's expected retire count
// and illegal flag are queued at issue and checked at retire.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0, reset = 1'b0, run = 1'b0, zero = 1'b0, mem_ack = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic             mem_req, mem_we, iorD, ir_write, pc_write, branch_taken, reg_Write;
    logic [1:0]       reg_Dest, memtoReg, aluop;
    logic             alu_Source, illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic [16:0]      obs;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iorD(iorD),
        .ir_write(ir_write), .pc_write(pc_write), .branch_taken(branch_taken),
        .reg_Write(reg_Write), .reg_Dest(reg_Dest), .memtoReg(memtoReg),
        .aluop(aluop), .alu_Source(alu_Source), .state(state),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, iorD, ir_write, pc_write, branch_taken, reg_Write,
                  reg_Dest, memtoReg, aluop, alu_Source, state};

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             ill;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] model_cnt = '0;
    logic             model_ill = 1'b0;
    int               n_checks = 0;
    int               n_fail = 0;

    // Issue one instruction from FETCH; fw/mw are memory wait cycles.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw,
                             input int mw, input logic next_run);
        logic [16:0] want;
        logic        is_r, is_lw, is_sw, is_beq, is_addi, legal, ex_src;
        logic [1:0]  ex_alu;
        exp_t        e;
        is_r    = (op == 6'd0);
        is_lw   = (op == 6'd4);
        is_sw   = (op == 6'd5);
        is_beq  = (op == 6'd6);
        is_addi = (op == 6'd7);
        legal   = is_r | is_lw | is_sw | is_beq | is_addi;
        if (legal) model_cnt = model_cnt + 1'b1;
        else       model_ill = 1'b1;
        e.cnt = model_cnt;
        e.ill = model_ill;
        sb.push_back(e);

        opcode = op;
        zero   = z;
        for (int i = 0; i < fw; i++) begin
            mem_ack = 1'b0;
            @(negedge clk);
            want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 3'd1};
            n_checks++;
            if (obs !== want) begin n_fail++; $display("FAIL fetch_wait op=%0d: got %h expected %h", op, obs, want); end
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        @(negedge clk);
        want = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 3'd1};
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL fetch_ack op=%0d: got %h expected %h", op, obs, want); end
        @(posedge clk); #1;

        // DECODE: ack here must be ignored; run change is not yet acted on
        run = next_run;
        @(negedge clk);
        want = {7'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd2};
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL decode op=%0d: got %h expected %h", op, obs, want); end
        @(posedge clk); #1;
        opcode = 6'h3F;

        if (is_r)                          begin ex_alu = 2'b00; ex_src = 1'b0; end
        else if (is_lw | is_sw | is_addi)  begin ex_alu = 2'b11; ex_src = 1'b1; end
        else if (is_beq)                   begin ex_alu = 2'b01; ex_src = 1'b0; end
        else                               begin ex_alu = 2'b00; ex_src = 1'b0; end
        @(negedge clk);
        want = {5'b0, is_beq & z, 1'b0, 4'b0, ex_alu, ex_src, 3'd3};
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL exec op=%0d: got %h expected %h", op, obs, want); end
        @(posedge clk); #1;
        mem_ack = 1'b0;

        if (is_lw | is_sw) begin
            want = {1'b1, is_sw, 1'b1, 3'b0, 1'b0, 4'b0, 2'b11, 1'b1, 3'd4};
            for (int i = 0; i < mw; i++) begin
                mem_ack = 1'b0;
                @(negedge clk);
                n_checks++;
                if (obs !== want) begin n_fail++; $display("FAIL mem_wait op=%0d: got %h expected %h", op, obs, want); end
                @(posedge clk); #1;
            end
            mem_ack = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== want) begin n_fail++; $display("FAIL mem_ack op=%0d: got %h expected %h", op, obs, want); end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end

        if (is_r | is_lw | is_addi) begin
            @(negedge clk);
            want = {6'b0, 1'b1, is_r ? 2'b01 : 2'b00, is_lw ? 2'b01 : 2'b00, 2'b00, 1'b0, 3'd5};
            n_checks++;
            if (obs !== want) begin n_fail++; $display("FAIL wb op=%0d: got %h expected %h", op, obs, want); end
            @(posedge clk); #1;
        end

        // Just past the retire edge
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL scoreboard_empty op=%0d", op);
        end else begin
            e = sb.pop_front();
            if (retired !== e.cnt) begin n_fail++; $display("FAIL retired op=%0d: got %0d expected %0d", op, retired, e.cnt); end
            n_checks++;
            if (illegal !== e.ill) begin n_fail++; $display("FAIL illegal op=%0d: got %b expected %b", op, illegal, e.ill); end
        end
        n_checks++;
        if (state !== (next_run ? 3'd1 : 3'd0)) begin
            n_fail++; $display("FAIL next_state op=%0d: got %0d expected %0d", op, state, next_run ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 17'd0); end
        n_checks++;
        if ({retired, illegal} !== '0) begin n_fail++; $display("FAIL reset_status: got retired=%0d illegal=%b expected 0 0", retired, illegal); end
        reset = 1'b1;
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", obs, 17'd0); end
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        run = 1'b1;
        @(posedge clk); #1;
        run_instr(6'd0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_lw();
        run_instr(6'd4, 1'b0, 2, 2, 1'b1);
    endtask

    task automatic test_sw();
        run_instr(6'd5, 1'b0, 0, 2, 1'b1);
    endtask

    task automatic test_beq();
        run_instr(6'd6, 1'b1, 0, 0, 1'b1);
        run_instr(6'd6, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_mem();
        run = 1'b1; opcode = 6'd4; mem_ack = 1'b1;
        @(posedge clk); #1;   // FETCH
        @(posedge clk); #1;   // DECODE
        @(posedge clk); #1;   // EXEC
        mem_ack = 1'b0;
        @(posedge clk); #1;   // MEM, waiting
        @(negedge clk);
        n_checks++;
        if ({mem_req, state} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL mem_before_reset: got req=%b state=%0d expected 1 4", mem_req, state); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL async_reset_drop: got %h expected %h", obs, 17'd0); end
        n_checks++;
        if (retired !== '0) begin n_fail++; $display("FAIL async_reset_retired: got %0d expected 0", retired); end
        model_cnt = '0; model_ill = 1'b0; sb.delete();
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, 17'd0); end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL fetch_after_reset: got %0d expected 1", state); end
    endtask

    task automatic test_illegal_wrap();
        logic [5:0] ops [5];
        ops[0] = 6'd0; ops[1] = 6'd4; ops[2] = 6'd5; ops[3] = 6'd6; ops[4] = 6'd7;
        run_instr(6'd9, 1'b0, 0, 0, 1'b1);
        // Bring the counter to all-ones with a mix of legal instructions
        for (int i = 0; i < (1 << CNT_W) - 1; i++)
            run_instr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
        n_checks++;
        if (retired !== '1) begin n_fail++; $display("FAIL preset_all_ones: got %0d expected %0d", retired, (1 << CNT_W) - 1); end
        run_instr(6'd7, 1'b0, 0, 0, 1'b0);
        n_checks++;
        if ({illegal, retired} !== {1'b1, {CNT_W{1'b0}}}) begin
            n_fail++; $display("FAIL wrap_sticky: got illegal=%b retired=%0d expected 1 0", illegal, retired);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_beq();
        test_reset_mid_mem();
        test_illegal_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the processor datapath. It steps each instruction through IDLE, FETCH, DECODE, EXEC, MEM and WB states. It issues per-state datapath controls and a request/acknowledge handshake to the shared instruction/data memory. It sits between the instruction register (opcode field instr[31:26]) and the register file, ALU and memory port, and it uses the same opcode map as the single-cycle control decoder.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  permits a new fetch when high
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ack  in  1  memory completion; valid only while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- iorD  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  instruction register load strobe
- pc_write  out  1  PC <= PC+4 strobe
- branch_taken  out  1  PC <= branch target strobe
- reg_Write  out  1  register file write strobe
- reg_Dest  out  2  01 = rd, 00 = rt
- memtoReg  out  2  01 = memory data, 00 = ALU result
- aluop  out  2  00 = funct, 01 = subtract, 11 = add
- alu_Source  out  1  1 = immediate operand
- state  out  3  current state encoding
- illegal  out  1  sticky flag for an unsupported opcode
- retired  out  CNT_W  count of completed instructions

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Encodings 6 and 7 are unreachable and recover to IDLE.
- Opcode map: 6'd0 = R-type, 6'd4 = lw, 6'd5 = sw, 6'd6 = beq, 6'd7 = addi. All other values are illegal.
- IDLE: all strobes are 0. Moves to FETCH when run=1.
- FETCH:
  - Outputs: mem_req=1, iorD=0, aluop=11, alu_Source=0.
  - Waits in FETCH while mem_ack=0.
  - In the cycle mem_ack=1, ir_write=1 and pc_write=1 are asserted combinationally, and the next state is DECODE.
- DECODE: one cycle. Latches opcode into an internal register; all later states use the latched value. Next state is EXEC.
- EXEC:
  - R-type: aluop=00, alu_Source=0, then WB.
  - lw, sw, addi: aluop=11, alu_Source=1. lw and sw go to MEM; addi goes to WB.
  - beq: aluop=01, alu_Source=0, branch_taken=zero, then retire.
  - Illegal: set illegal=1 and retire with no side effects.
- MEM:
  - Outputs: mem_req=1, iorD=1, aluop=11, alu_Source=1, and mem_we=1 for sw.
  - Held until mem_ack. Then sw retires and lw goes to WB.
- WB: one cycle with reg_Write=1.
  - reg_Dest=01 for R-type, 00 for lw and addi.
  - memtoReg=01 for lw, 00 otherwise.
- Retire: means leaving EXEC, MEM or WB at the end of an instruction.
  - retired increments by 1 for every legal instruction and wraps from all-ones to 0. Illegal opcodes are not counted.
  - Next state is FETCH if run=1, otherwise IDLE.
- Default outputs: any field not listed for a state is 0.
- run is ignored mid-instruction; a deassertion takes effect only at retire or in IDLE.

## Timing
- Reset asserted (reset=0), immediately and asynchronously:
  - state=IDLE, all strobes 0.
  - reg_Dest, memtoReg and aluop = 00; alu_Source=0.
  - illegal=0, retired=0, latched opcode=0.
- Reset mid-access: mem_req drops at once and the access is abandoned. After release, the first rising edge with run=1 enters FETCH.
- Outputs are Moore by state, except three that are Mealy:
  - ir_write and pc_write: FETCH & mem_ack.
  - branch_taken: EXEC & beq & zero.
- Minimum latency with zero-wait memory (mem_ack high in the first request cycle), counted from entering FETCH to the retire edge: beq=3, R-type/addi/sw=4, lw=5 cycles. Each wait cycle adds 1.
- mem_ack while mem_req=0 is ignored.
- Back-to-back: with run held high, FETCH of the next instruction follows the retire edge with no bubble.
- Strobes are single-cycle pulses, except mem_req and mem_we, which are held for the whole wait period.

## Test plan
- Reset and run=0 for 5 cycles → state=0, all outputs 0, retired=0. Pulse reset low during MEM → mem_req falls within the same cycle and state=0.
- run=1, zero-wait memory, opcode=0 → states 1,2,3,5,1. reg_Write and reg_Dest=01 are asserted in state 5; retired=1.
- lw (opcode 4) with mem_ack delayed 2 cycles in both FETCH and MEM → 9 cycles to retire. In MEM, mem_req=1, iorD=1, mem_we=0. In WB, memtoReg=01.
- sw (opcode 5) → mem_we=1 for every MEM cycle; reg_Write is never asserted.
- beq (opcode 6) with zero=1 then zero=0 → branch_taken pulses in EXEC only in the zero=1 case. Each instruction retires in 3 cycles.
- Sequence of opcode=6'd9, then retired preset to 0xFFFF, then addi → illegal=1 stays set; no reg_Write for the illegal opcode; retired wraps to 0x0000 after the addi.
